// File: rtl/rgb_seq_pkg.sv
// Shared colour encoding and checker state types for the RGB LED sequencer and its checker.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        BLANK = 2'b00,
        RED   = 2'b01,
        GREEN = 2'b11,
        BLUE  = 2'b10
    } colour_e;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        S_RED,
        S_GREEN,
        S_BLUE
    } chk_state_e;

    typedef struct packed {
        logic    illegal;
        colour_e colour;
    } decode_t;

    // Anything other than all-off or exactly one line high is flagged illegal.
    function automatic decode_t decode_rgb(input logic r, input logic g, input logic b);
        decode_t d;
        d.illegal = 1'b0;
        d.colour  = BLANK;
        case ({r, g, b})
            3'b000:  d.colour  = BLANK;
            3'b100:  d.colour  = RED;
            3'b010:  d.colour  = GREEN;
            3'b001:  d.colour  = BLUE;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rgb_sequence_checker.sv
// Passive monitor of the RGB LED lines: checks one-hot, BLANK->RED->GREEN->BLUE->BLANK order and dwell,
// counts legal sequences and keeps sticky error flags. All outputs registered, one cycle after sampling.
module rgb_sequence_checker
    import rgb_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 10,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   red,
    input  logic                   green,
    input  logic                   blue,
    input  logic                   err_clear,
    output logic [1:0]             cur_colour,
    output logic                   seq_done,
    output logic [COUNT_WIDTH-1:0] seq_count,
    output logic                   err_onehot,
    output logic                   err_order,
    output logic                   err_dwell
);

    localparam int DW = $clog2(DWELL_CYCLES + 2);
    localparam logic [DW-1:0] DWELL_OK  = DW'(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_SAT = DW'(DWELL_CYCLES + 1);

    chk_state_e             state_q, state_d;
    logic [DW-1:0]          dwell_q, dwell_d;
    colour_e                cur_colour_q, cur_colour_d;
    logic                   seq_done_q, seq_done_d;
    logic [COUNT_WIDTH-1:0] seq_count_q, seq_count_d;
    logic                   err_onehot_q, err_onehot_d;
    logic                   err_order_q, err_order_d;
    logic                   err_dwell_q, err_dwell_d;

    decode_t    dec;
    colour_e    own_colour, succ_colour;
    chk_state_e succ_state;
    logic       set_onehot, set_order, set_dwell;

    always_comb begin
        dec          = decode_rgb(red, green, blue);
        state_d      = state_q;
        dwell_d      = dwell_q;
        cur_colour_d = dec.illegal ? cur_colour_q : dec.colour;
        seq_done_d   = 1'b0;
        seq_count_d  = seq_count_q;
        set_onehot   = 1'b0;
        set_order    = 1'b0;
        set_dwell    = 1'b0;
        own_colour   = BLANK;
        succ_colour  = BLANK;
        succ_state   = IDLE;

        case (state_q)
            S_RED:   begin own_colour = RED;   succ_colour = GREEN; succ_state = S_GREEN; end
            S_GREEN: begin own_colour = GREEN; succ_colour = BLUE;  succ_state = S_BLUE;  end
            S_BLUE:  begin own_colour = BLUE;  succ_colour = BLANK; succ_state = IDLE;    end
            default: ;
        endcase

        if (dec.illegal) begin
            set_onehot = 1'b1;
            state_d    = SYNC;
            dwell_d    = '0;
        end else begin
            case (state_q)
                // Resync point: wait for a gap before trusting the order again.
                SYNC: begin
                    if (dec.colour == BLANK) begin
                        state_d = IDLE;
                        dwell_d = '0;
                    end
                end
                IDLE: begin
                    if (dec.colour == RED) begin
                        state_d = S_RED;
                        dwell_d = DW'(1);
                    end else if (dec.colour != BLANK) begin
                        set_order = 1'b1;
                        state_d   = SYNC;
                    end
                end
                default: begin
                    if (dec.colour == own_colour) begin
                        if (dwell_q != DWELL_SAT) begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end else if (dec.colour == succ_colour) begin
                        if (dwell_q != DWELL_OK) begin
                            set_dwell = 1'b1;
                            state_d   = (state_q == S_BLUE) ? IDLE : SYNC;
                            dwell_d   = '0;
                        end else begin
                            state_d = succ_state;
                            dwell_d = (state_q == S_BLUE) ? '0 : DW'(1);
                            if (state_q == S_BLUE) begin
                                seq_done_d  = 1'b1;
                                seq_count_d = seq_count_q + COUNT_WIDTH'(1);
                            end
                        end
                    end else begin
                        set_order = 1'b1;
                        state_d   = SYNC;
                        dwell_d   = '0;
                    end
                end
            endcase
        end

        // A new error in the same cycle as err_clear keeps the flag set.
        err_onehot_d = set_onehot | (err_onehot_q & ~err_clear);
        err_order_d  = set_order  | (err_order_q  & ~err_clear);
        err_dwell_d  = set_dwell  | (err_dwell_q  & ~err_clear);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SYNC;
            dwell_q      <= '0;
            cur_colour_q <= BLANK;
            seq_done_q   <= 1'b0;
            seq_count_q  <= '0;
            err_onehot_q <= 1'b0;
            err_order_q  <= 1'b0;
            err_dwell_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            cur_colour_q <= cur_colour_d;
            seq_done_q   <= seq_done_d;
            seq_count_q  <= seq_count_d;
            err_onehot_q <= err_onehot_d;
            err_order_q  <= err_order_d;
            err_dwell_q  <= err_dwell_d;
        end
    end

    assign cur_colour = cur_colour_q;
    assign seq_done   = seq_done_q;
    assign seq_count  = seq_count_q;
    assign err_onehot = err_onehot_q;
    assign err_order  = err_order_q;
    assign err_dwell  = err_dwell_q;

endmodule

// File: tb/tb_rgb_sequence_checker.sv
// Directed bench for rgb_sequence_checker: a default instance plus a COUNT_WIDTH=2 instance for wrap checks.
module tb_rgb_sequence_checker;

    localparam logic [2:0] C_BLANK = 3'b000;
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_BLUE  = 3'b001;
    localparam logic [2:0] C_RG    = 3'b110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic        red = 1'b0, green = 1'b0, blue = 1'b0;
    logic        err_clear = 1'b0;

    logic [1:0]  cur_colour, cur_colour2;
    logic        seq_done, seq_done2;
    logic [15:0] seq_count;
    logic [1:0]  seq_count2;
    logic        err_onehot, err_order, err_dwell;
    logic        err_onehot2, err_order2, err_dwell2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rgb_sequence_checker #(.DWELL_CYCLES(10), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue), .err_clear(err_clear),
        .cur_colour(cur_colour), .seq_done(seq_done), .seq_count(seq_count),
        .err_onehot(err_onehot), .err_order(err_order), .err_dwell(err_dwell)
    );

    rgb_sequence_checker #(.DWELL_CYCLES(10), .COUNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset2), .red(red), .green(green), .blue(blue), .err_clear(err_clear),
        .cur_colour(cur_colour2), .seq_done(seq_done2), .seq_count(seq_count2),
        .err_onehot(err_onehot2), .err_order(err_order2), .err_dwell(err_dwell2)
    );

    // Drive one sample at negedge; return just after the posedge that registers it.
    task automatic cyc(input logic [2:0] rgb, input logic clr);
        @(negedge clk);
        {red, green, blue} = rgb;
        err_clear = clr;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
    endtask

    task automatic hold(input logic [2:0] rgb, input int n);
        for (int i = 0; i < n; i++) cyc(rgb, 1'b0);
    endtask

    task automatic run_seq();
        cyc(C_BLANK, 1'b0);
        hold(C_RED, 10);
        hold(C_GREEN, 10);
        hold(C_BLUE, 10);
        cyc(C_BLANK, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reset2 = 1'b1;
        #3;
        tests_run++;
        if ({cur_colour, seq_done, seq_count, err_onehot, err_order, err_dwell} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got col=%b done=%b cnt=%0d oh=%b ord=%b dw=%b, want all 0",
                     cur_colour, seq_done, seq_count, err_onehot, err_order, err_dwell);
        end
        @(negedge clk);
        reset = 1'b0;
        reset2 = 1'b0;
    endtask

    task automatic test_legal_sequence();
        hold(C_BLANK, 3);
        hold(C_RED, 10);
        tests_run++;
        if (cur_colour !== 2'b01) begin
            tests_failed++; $display("FAIL t1_cur_red: got %b want 01", cur_colour);
        end
        hold(C_GREEN, 10);
        tests_run++;
        if (cur_colour !== 2'b11) begin
            tests_failed++; $display("FAIL t1_cur_green: got %b want 11", cur_colour);
        end
        hold(C_BLUE, 10);
        tests_run++;
        if (seq_done !== 1'b0 || seq_count !== 16'd0) begin
            tests_failed++; $display("FAIL t1_pre_done: got done=%b cnt=%0d want 0/0", seq_done, seq_count);
        end
        cyc(C_BLANK, 1'b0);
        tests_run++;
        if (seq_done !== 1'b1 || seq_count !== 16'd1) begin
            tests_failed++; $display("FAIL t1_done: got done=%b cnt=%0d want 1/1", seq_done, seq_count);
        end
        cyc(C_BLANK, 1'b0);
        tests_run++;
        if (seq_done !== 1'b0 || {err_onehot, err_order, err_dwell} !== 3'b000) begin
            tests_failed++;
            $display("FAIL t1_pulse_errs: got done=%b errs=%b want 0/000", seq_done, {err_onehot, err_order, err_dwell});
        end
    endtask

    task automatic test_short_dwell();
        hold(C_RED, 9);
        cyc(C_GREEN, 1'b0);
        tests_run++;
        if (err_dwell !== 1'b1 || err_order !== 1'b0 || seq_done !== 1'b0 || seq_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL t2_dwell: got dw=%b ord=%b done=%b cnt=%0d want 1/0/0/1", err_dwell, err_order, seq_done, seq_count);
        end
        // In SYNC the rest of the sequence must be ignored.
        hold(C_GREEN, 9);
        hold(C_BLUE, 10);
        cyc(C_BLANK, 1'b0);
        tests_run++;
        if (seq_done !== 1'b0 || seq_count !== 16'd1 || err_order !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_sync: got done=%b cnt=%0d ord=%b want 0/1/0", seq_done, seq_count, err_order);
        end
        cyc(C_BLANK, 1'b1);
        tests_run++;
        if (err_dwell !== 1'b0) begin
            tests_failed++; $display("FAIL t2_clear: got dw=%b want 0", err_dwell);
        end
    endtask

    task automatic test_order_and_clear();
        cyc(C_BLANK, 1'b0);
        hold(C_RED, 10);
        cyc(C_BLUE, 1'b0);
        tests_run++;
        if (err_order !== 1'b1 || err_dwell !== 1'b0) begin
            tests_failed++; $display("FAIL t3_order: got ord=%b dw=%b want 1/0", err_order, err_dwell);
        end
        cyc(C_BLANK, 1'b0);
        tests_run++;
        if (err_order !== 1'b1) begin
            tests_failed++; $display("FAIL t3_sticky: got ord=%b want 1", err_order);
        end
        cyc(C_BLANK, 1'b1);
        tests_run++;
        if (err_order !== 1'b0) begin
            tests_failed++; $display("FAIL t3_clear: got ord=%b want 0", err_order);
        end
        // GREEN from IDLE is an order error in the same cycle as the clear.
        cyc(C_GREEN, 1'b1);
        tests_run++;
        if (err_order !== 1'b1) begin
            tests_failed++; $display("FAIL t3_set_wins: got ord=%b want 1", err_order);
        end
        cyc(C_BLANK, 1'b1);
        tests_run++;
        if (err_order !== 1'b0 || seq_count !== 16'd1) begin
            tests_failed++; $display("FAIL t3_final: got ord=%b cnt=%0d want 0/1", err_order, seq_count);
        end
    endtask

    task automatic test_onehot();
        cyc(C_BLANK, 1'b0);
        hold(C_RED, 10);
        hold(C_GREEN, 5);
        cyc(C_RG, 1'b0);
        tests_run++;
        if (err_onehot !== 1'b1 || cur_colour !== 2'b11 || err_order !== 1'b0 || err_dwell !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_onehot: got oh=%b col=%b ord=%b dw=%b want 1/11/0/0", err_onehot, cur_colour, err_order, err_dwell);
        end
        hold(C_GREEN, 5);
        hold(C_BLUE, 10);
        cyc(C_BLANK, 1'b0);
        tests_run++;
        if (seq_done !== 1'b0 || seq_count !== 16'd1) begin
            tests_failed++; $display("FAIL t4_resync: got done=%b cnt=%0d want 0/1", seq_done, seq_count);
        end
        run_seq();
        tests_run++;
        if (seq_done !== 1'b1 || seq_count !== 16'd2 || err_order !== 1'b0 || err_dwell !== 1'b0) begin
            tests_failed++;
            $display("FAIL t4_recover: got done=%b cnt=%0d ord=%b dw=%b want 1/2/0/0", seq_done, seq_count, err_order, err_dwell);
        end
        cyc(C_BLANK, 1'b1);
    endtask

    task automatic test_midseq_reset();
        cyc(C_BLANK, 1'b0);
        hold(C_RED, 10);
        hold(C_GREEN, 3);
        @(negedge clk);
        reset = 1'b1;
        #2;
        tests_run++;
        if (cur_colour !== 2'b00 || seq_count !== 16'd0) begin
            tests_failed++; $display("FAIL t5_reset: got col=%b cnt=%0d want 00/0", cur_colour, seq_count);
        end
        @(negedge clk);
        reset = 1'b0;
        hold(C_GREEN, 5);
        hold(C_BLUE, 10);
        tests_run++;
        if ({err_onehot, err_order, err_dwell} !== 3'b000 || cur_colour !== 2'b10) begin
            tests_failed++;
            $display("FAIL t5_quiet: got errs=%b col=%b want 000/10", {err_onehot, err_order, err_dwell}, cur_colour);
        end
        cyc(C_BLANK, 1'b0);
        tests_run++;
        if (seq_done !== 1'b0 || err_dwell !== 1'b0) begin
            tests_failed++; $display("FAIL t5_blank: got done=%b dw=%b want 0/0", seq_done, err_dwell);
        end
        run_seq();
        tests_run++;
        if (seq_done !== 1'b1 || seq_count !== 16'd1 || {err_onehot, err_order, err_dwell} !== 3'b000) begin
            tests_failed++;
            $display("FAIL t5_count: got done=%b cnt=%0d errs=%b want 1/1/000", seq_done, seq_count, {err_onehot, err_order, err_dwell});
        end
    endtask

    task automatic test_wrap_and_stuck();
        logic [1:0] exp_cnt [4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0;
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_seq();
            tests_run++;
            if (seq_count2 !== exp_cnt[k] || seq_done2 !== 1'b1) begin
                tests_failed++;
                $display("FAIL t6_wrap%0d: got cnt=%0d done=%b want %0d/1", k, seq_count2, seq_done2, exp_cnt[k]);
            end
        end
        cyc(C_BLANK, 1'b0);
        hold(C_RED, 10);
        hold(C_GREEN, 20);
        tests_run++;
        if (err_dwell2 !== 1'b0 || err_order2 !== 1'b0) begin
            tests_failed++; $display("FAIL t6_stuck_quiet: got dw=%b ord=%b want 0/0", err_dwell2, err_order2);
        end
        cyc(C_BLUE, 1'b0);
        tests_run++;
        if (err_dwell2 !== 1'b1 || err_dwell !== 1'b1 || seq_count2 !== 2'd0) begin
            tests_failed++;
            $display("FAIL t6_stuck_change: got dw2=%b dw=%b cnt2=%0d want 1/1/0", err_dwell2, err_dwell, seq_count2);
        end
    endtask

    initial begin
        test_reset();
        test_legal_sequence();
        test_short_dwell();
        test_order_and_clear();
        test_onehot();
        test_midseq_reset();
        test_wrap_and_stuck();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
